leaf_stream_sender: RTL and testbench
=====================================

LEAF_STREAM_SENDER -- requirements
Module: leaf_stream_sender

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 5, leaf-address field width.
- NUM_PORT_BITS, 4, port field width.
- NUM_ADDR_BITS, 7, receiver write-address field width.
- NUM_BRAM_ADDR_BITS, 7, receiver buffer depth is 2^this.
- FREESPACE_UPDATE_SIZE, 64, credits per freespace update.
- SELF_LEAF, 0, this leaf's address.
- SRC_PORT, 1, this sender's output port index (1..15).
- DEST_LEAF, 1, destination leaf.
- DEST_PORT, 1, destination input port.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous active-high reset.
- din_leaf_user2interface, in, PAYLOAD_BITS, user data word.
- vld_user2interface, in, 1, user word valid.
- ack_interface2user, out, 1, word accepted this cycle.
- din_leaf_bft2interface, in, PACKET_BITS, packets from BFT (credit returns).
- dout_leaf_interface2bft, out, PACKET_BITS, packets to BFT.
- resend, in, 1, network replay request; forces stall.
- credit, out, NUM_BRAM_ADDR_BITS+1, current credit count.
- credit_err, out, 1, sticky credit-overflow flag.

Function
REQ-003 Outgoing packet layout SHALL be:
- [48] valid.
- [47:43] DEST_LEAF.
- [42:39] DEST_PORT.
- [38:32] wr_addr.
- [31:0] payload.
REQ-004 A word SHALL transfer only in a cycle where vld_user2interface=1 and ack_interface2user=1.
REQ-005 ack_interface2user SHALL be combinational and asserted only when all hold: state==RUN, credit>0, resend=0.
REQ-006 On a transfer, dout_leaf_interface2bft SHALL present the packet on the next cycle (one-cycle registered latency).
REQ-007 In every cycle without a transfer, dout_leaf_interface2bft SHALL be all-zero on the next cycle.
REQ-008 wr_addr SHALL increment by one per transfer, modulo 2^NUM_ADDR_BITS (127 wraps to 0).
REQ-009 A credit-return packet SHALL be recognised only when all hold:
- din[48]=1.
- din[47:43]=SELF_LEAF.
- din[42:39]=0.
- din[3:0]=SRC_PORT.
REQ-010 Per cycle, credit SHALL update as credit - transfer + (credit-return ? FREESPACE_UPDATE_SIZE : 0).
REQ-011 A simultaneous transfer and credit return SHALL both be applied in the same cycle (net +63 at defaults).
REQ-012 If the REQ-010 result exceeds 2^NUM_BRAM_ADDR_BITS, credit SHALL saturate at 2^NUM_BRAM_ADDR_BITS and credit_err SHALL set, staying set until reset.
REQ-013 The state machine SHALL have states RUN, NO_CREDIT and HOLD.
REQ-014 RUN->NO_CREDIT SHALL occur when the next-cycle credit equals 0.
REQ-015 NO_CREDIT->RUN SHALL occur on the cycle after a credit return brings credit above 0.
REQ-016 Any state->HOLD SHALL occur while resend=1; the resend check has priority over all other transitions.
REQ-017 HOLD SHALL exit on the cycle after resend falls, to RUN if credit>0, else NO_CREDIT.
REQ-018 A transfer accepted in the cycle before resend rises SHALL still be emitted; no packet is dropped or duplicated.
REQ-019 Non-credit packets on din_leaf_bft2interface SHALL be ignored.
REQ-020 Credit returns SHALL be counted in every state, including HOLD.

Reset
REQ-021 While reset=1, the block SHALL immediately hold:
- state=RUN.
- credit=2^NUM_BRAM_ADDR_BITS (128).
- wr_addr=0.
- dout_leaf_interface2bft=0.
- credit_err=0.
- ack_interface2user=0.
REQ-022 Reset asserted mid-stream SHALL discard the pending output packet and SHALL NOT emit a partial packet on release.

Verification
REQ-023 Bench SHALL cover the following directed scenarios:
- Reset, then 3 words 0xA,0xB,0xC with vld held high -> packets with addr 0,1,2, payloads 0xA..0xC, DEST fields set, valid=1; credit=125.
- 128 back-to-back words with no credit return -> 128 packets, addr wraps 127->0; credit=0; ack low; state NO_CREDIT; 129th word not accepted.
- In NO_CREDIT, inject one credit return (SELF_LEAF, port 0, payload[3:0]=SRC_PORT) -> credit=64; ack high from the following cycle.
- Credit return in the same cycle as a transfer at credit=10 -> credit=73.
- Credit return at credit=100 -> credit=128 and credit_err=1, still 1 after 50 idle cycles.
- resend pulsed for 5 cycles during streaming -> ack low and dout zero during resend; no lost or duplicated addr; streaming resumes one cycle after resend falls.

Source files
------------

// File: rtl/leaf_stream_sender_if.sv
// leaf_stream_sender_if: user word stream, BFT packet ports and credit status of a leaf sender.
// master is the sender side; slave is the user/network side.
interface leaf_stream_sender_if #(
    parameter int PACKET_BITS        = 49,
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_BRAM_ADDR_BITS = 7
);
    logic [PAYLOAD_BITS-1:0]     din_leaf_user2interface;
    logic                        vld_user2interface;
    logic                        ack_interface2user;
    logic [PACKET_BITS-1:0]      din_leaf_bft2interface;
    logic [PACKET_BITS-1:0]      dout_leaf_interface2bft;
    logic                        resend;
    logic [NUM_BRAM_ADDR_BITS:0] credit;
    logic                        credit_err;

    modport master (
        input  din_leaf_user2interface, vld_user2interface, din_leaf_bft2interface, resend,
        output ack_interface2user, dout_leaf_interface2bft, credit, credit_err
    );
    modport slave (
        output din_leaf_user2interface, vld_user2interface, din_leaf_bft2interface, resend,
        input  ack_interface2user, dout_leaf_interface2bft, credit, credit_err
    );
endinterface

// File: rtl/leaf_stream_sender.sv
// leaf_stream_sender: packs user words into BFT packets with a rolling write address,
// gated by a credit counter replenished by credit-return packets from the receiver.
module leaf_stream_sender #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int SELF_LEAF             = 0,
    parameter int SRC_PORT              = 1,
    parameter int DEST_LEAF             = 1,
    parameter int DEST_PORT             = 1
) (
    input logic clk,
    input logic reset,
    leaf_stream_sender_if.master bus
);
    localparam int CW = NUM_BRAM_ADDR_BITS + 1;
    localparam int PORT_MSB = PACKET_BITS - 2 - NUM_LEAF_BITS;
    localparam logic [CW:0] CMAX = {2'b01, {NUM_BRAM_ADDR_BITS{1'b0}}};
    localparam logic [CW:0] CUPD = (CW + 1)'(FREESPACE_UPDATE_SIZE);

    typedef enum logic [1:0] {RUN, NO_CREDIT, HOLD} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] credit, credit_nxt;
    logic [CW:0] sum;
    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic [PACKET_BITS-1:0] dout;
    logic credit_err, err_nxt, xfer, cret, ack;
    logic [PACKET_BITS-1:0] din;
    logic unused_din;

    assign din = bus.din_leaf_bft2interface;
    assign unused_din = ^din[PORT_MSB-NUM_PORT_BITS:NUM_PORT_BITS];
    assign cret = din[PACKET_BITS-1]
               && din[PACKET_BITS-2 -: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF)
               && din[PORT_MSB -: NUM_PORT_BITS] == '0
               && din[NUM_PORT_BITS-1:0] == NUM_PORT_BITS'(SRC_PORT);
    // reset is folded in so ack stays low while the block is held in reset
    assign ack = !reset && state == RUN && credit != '0 && !bus.resend;
    assign xfer = ack && bus.vld_user2interface;

    always_comb begin
        sum = {1'b0, credit} - (CW + 1)'(xfer) + (cret ? CUPD : '0);
        credit_nxt = sum > CMAX ? CMAX[CW-1:0] : sum[CW-1:0];
        err_nxt = credit_err || sum > CMAX;
        state_nxt = bus.resend ? HOLD : credit_nxt == '0 ? NO_CREDIT : RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit <= CMAX[CW-1:0];
            credit_err <= 1'b0;
            wr_addr <= '0;
            dout <= '0;
        end else begin
            credit <= credit_nxt;
            credit_err <= err_nxt;
            wr_addr <= wr_addr + NUM_ADDR_BITS'(xfer);
            dout <= xfer ? {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT), wr_addr,
                            bus.din_leaf_user2interface} : '0;
        end
    end

    assign bus.ack_interface2user = ack;
    assign bus.dout_leaf_interface2bft = dout;
    assign bus.credit = credit;
    assign bus.credit_err = credit_err;
endmodule

// File: tb/tb_leaf_stream_sender.sv
// tb_leaf_stream_sender: scoreboard bench; a credit/address model predicts packets and ack,
// a separate monitor pops expected packets whenever the sender emits one.
module tb_leaf_stream_sender;
    localparam int SELF = 0, SRC = 1, DL = 1, DP = 1;

    typedef struct {
        logic [48:0] pkt;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    leaf_stream_sender_if bus();
    leaf_stream_sender dut (.clk(clk), .reset(rst), .bus(bus));

    exp_t q[$];
    exp_t e;
    int checks = 0, failures = 0, cy = 0;
    int credit_m = 128, addr_m = 0, c;
    bit err_m = 0, resend_prev = 0, ea, x;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] ex);
        checks++;
        if (a !== ex) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, ex);
        end
    endtask

    function automatic bit is_ret(input logic [48:0] p);
        return p[48] && p[47:43] == 5'(SELF) && p[42:39] == 4'd0 && p[3:0] == 4'(SRC);
    endfunction

    function automatic logic [48:0] ret_pkt();
        logic [48:0] p;
        p = {17'($urandom), $urandom};
        p[48] = 1'b1;
        p[47:43] = 5'(SELF);
        p[42:39] = 4'd0;
        p[3:0] = 4'(SRC);
        return p;
    endfunction

    // a credit-return lookalike with exactly one recognition field broken
    function automatic logic [48:0] miss_pkt();
        logic [48:0] p;
        p = ret_pkt();
        case ($urandom_range(3))
            0: p[48] = 1'b0;
            1: p[47:43] = p[47:43] ^ 5'($urandom_range(30) + 1);
            2: p[42:39] = 4'($urandom_range(14) + 1);
            default: p[3:0] = p[3:0] ^ 4'($urandom_range(14) + 1);
        endcase
        return p;
    endfunction

    always @(posedge clk) cy <= cy + 1;

    // reference model: ack needs credit and no resend this cycle or the one before
    always @(negedge clk) begin
        if (rst) begin
            credit_m = 128;
            addr_m = 0;
            err_m = 0;
            resend_prev = 0;
            q.delete();
        end else begin
            ea = credit_m > 0 && !bus.resend && !resend_prev;
            chk("ack", bus.ack_interface2user, ea);
            chk("credit", bus.credit, credit_m);
            chk("credit_err", bus.credit_err, err_m);
            x = bus.vld_user2interface && ea;
            if (x) begin
                q.push_back('{pkt: {1'b1, 5'(DL), 4'(DP), 7'(addr_m), bus.din_leaf_user2interface}, cyc: cy});
                addr_m = (addr_m + 1) % 128;
            end
            c = credit_m - int'(x) + (is_ret(bus.din_leaf_bft2interface) ? 64 : 0);
            if (c > 128) begin
                c = 128;
                err_m = 1;
            end
            credit_m = c;
            resend_prev = bus.resend;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dout_leaf_interface2bft[48]) begin
                if (q.size() == 0) chk("dout_unexpected", bus.dout_leaf_interface2bft, 0);
                else begin
                    e = q.pop_front();
                    chk("pkt", bus.dout_leaf_interface2bft, e.pkt);
                    chk("latency", cy, e.cyc + 1);
                end
            end else chk("dout_idle", bus.dout_leaf_interface2bft, 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        bus.vld_user2interface = 1'b1;
        bus.din_leaf_user2interface = w;
        cyc();
    endtask

    task automatic idle(input int n);
        bus.vld_user2interface = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.vld_user2interface = 1'b0;
        bus.din_leaf_user2interface = '0;
        bus.din_leaf_bft2interface = '0;
        bus.resend = 1'b0;
        #1;
        chk("rst_credit", bus.credit, 128);
        chk("rst_ack", bus.ack_interface2user, 0);
        chk("rst_dout", bus.dout_leaf_interface2bft, 0);
        chk("rst_err", bus.credit_err, 0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int r;
        do_reset();
        send(32'hA);
        chk("pkt_first", bus.dout_leaf_interface2bft, {1'b1, 5'd1, 4'd1, 7'd0, 32'hA});
        send(32'hB);
        send(32'hC);
        bus.vld_user2interface = 1'b0;
        chk("pkt_third", bus.dout_leaf_interface2bft, {1'b1, 5'd1, 4'd1, 7'd2, 32'hC});
        chk("credit_abc", bus.credit, 125);
        idle(2);

        do_reset();
        repeat (128) send($urandom);
        chk("credit_empty", bus.credit, 0);
        bus.din_leaf_user2interface = 32'h129;
        repeat (3) begin
            chk("ack_empty", bus.ack_interface2user, 0);
            cyc();
        end
        bus.vld_user2interface = 1'b0;
        bus.din_leaf_bft2interface = ret_pkt();
        cyc();
        bus.din_leaf_bft2interface = '0;
        chk("credit_ret", bus.credit, 64);
        chk("ack_ret", bus.ack_interface2user, 1);

        repeat (54) send($urandom);
        chk("credit_10", bus.credit, 10);
        bus.din_leaf_bft2interface = ret_pkt();
        send($urandom);
        bus.din_leaf_bft2interface = '0;
        bus.vld_user2interface = 1'b0;
        chk("credit_73", bus.credit, 73);

        do_reset();
        repeat (28) send($urandom);
        bus.vld_user2interface = 1'b0;
        chk("credit_100", bus.credit, 100);
        bus.din_leaf_bft2interface = ret_pkt();
        cyc();
        bus.din_leaf_bft2interface = '0;
        chk("credit_sat", bus.credit, 128);
        chk("err_set", bus.credit_err, 1);
        idle(50);
        chk("err_sticky", bus.credit_err, 1);

        repeat (4) send($urandom);
        bus.resend = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din_leaf_user2interface = $urandom;
            #1;
            chk("ack_resend", bus.ack_interface2user, 0);
            if (i > 0) chk("dout_resend", bus.dout_leaf_interface2bft, 0);
            cyc();
        end
        bus.resend = 1'b0;
        #1;
        chk("ack_hold_exit", bus.ack_interface2user, 0);
        cyc();
        chk("ack_resume", bus.ack_interface2user, 1);
        repeat (4) send($urandom);
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            bus.vld_user2interface = $urandom_range(9) < 7;
            bus.din_leaf_user2interface = $urandom;
            r = $urandom_range(99);
            bus.din_leaf_bft2interface = r < 1 ? ret_pkt() : r < 5 ? miss_pkt() :
                                         r < 8 ? {17'($urandom), $urandom} : '0;
            bus.resend = $urandom_range(99) < 3;
            if (i == 1000) do_reset();
            else cyc();
        end
        bus.vld_user2interface = 1'b0;
        bus.din_leaf_bft2interface = '0;
        bus.resend = 1'b0;
        idle(3);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
